// File: rtl/pulse_event_arbiter.sv
// Rising-edge event collector: synchronises N level inputs, latches edges as pending
// requests and hands them one at a time, round-robin, to a valid/ready event port.
module pulse_event_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   level_in,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic [N-1:0]   evt_overflow,
    input  logic           clear_overflow
);

    logic [N-1:0]   reg1;
    logic [N-1:0]   reg2;
    logic [N-1:0]   pending;
    logic [N-1:0]   edge_det;
    logic [N-1:0]   grant_vec;
    logic [N-1:0]   overflow_set;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] sel_id;
    logic           load;

    // First set request after 'last', wrapping around; 'last' itself is checked last.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0]   req,
                                               input logic [IDW-1:0] last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
        return pick;
    endfunction

    always_comb begin
        edge_det     = reg1 & ~reg2;
        load         = (!evt_valid || evt_ready) && (|pending);
        sel_id       = rr_pick(pending, last_grant);
        grant_vec    = load ? (N'(1) << sel_id) : '0;
        overflow_set = edge_det & pending & ~grant_vec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg1 <= '0;
            reg2 <= '0;
        end else begin
            reg1 <= level_in;
            reg2 <= reg1;
        end
    end

    // A fresh edge on a channel being granted this cycle re-arms it as a new event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_vec) | edge_det;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_overflow <= '0;
        end else if (clear_overflow) begin
            evt_overflow <= overflow_set;
        end else begin
            evt_overflow <= evt_overflow | overflow_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            last_grant <= IDW'(N - 1);
        end else if (load) begin
            evt_valid  <= 1'b1;
            evt_id     <= sel_id;
            last_grant <= sel_id;
        end else if (evt_valid && evt_ready) begin
            evt_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Bench for pulse_event_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the event collector.
module tb_pulse_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   level_in;
    logic           evt_valid;
    logic           evt_ready;
    logic [IDW-1:0] evt_id;
    logic [N-1:0]   evt_overflow;
    logic           clear_overflow;

    int checks   = 0;
    int failures = 0;

    bit [N-1:0] m_r1, m_r2, m_pend, m_ovf;
    bit         m_valid;
    int         m_id, m_last;

    pulse_event_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .level_in       (level_in),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_id         (evt_id),
        .evt_overflow   (evt_overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r1 = '0; m_r2 = '0; m_pend = '0; m_ovf = '0;
        m_valid = 1'b0; m_id = 0; m_last = N - 1;
    endtask

    // One clock edge of the event rules, using the inputs as they stand before the edge.
    task automatic model_step();
        bit [N-1:0] e;
        bit [N-1:0] setov;
        bit         ld;
        int         sel;
        sel   = -1;
        e     = m_r1 & ~m_r2;
        ld    = (!m_valid || evt_ready) && (m_pend != 0);
        setov = '0;
        if (ld) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (sel < 0 && m_pend[c]) sel = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (e[i] && m_pend[i] && !(ld && sel == i)) setov[i] = 1'b1;
            if (ld && sel == i) m_pend[i] = 1'b0;
            if (e[i]) m_pend[i] = 1'b1;
        end
        m_ovf = clear_overflow ? setov : (m_ovf | setov);
        if (ld) begin
            m_valid = 1'b1; m_id = sel; m_last = sel;
        end else if (m_valid && evt_ready) begin
            m_valid = 1'b0;
        end
        m_r2 = m_r1;
        m_r1 = level_in;
    endtask

    task automatic compare_model();
        check_val("valid", 32'(evt_valid), 32'(m_valid));
        check_val("id", 32'(evt_id), 32'(m_id));
        check_val("overflow", 32'(evt_overflow), 32'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        level_in       = '0;
        clear_overflow = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        reset_n        = 1'b0;
        level_in       = '0;
        evt_ready      = 1'b0;
        clear_overflow = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_valid", 32'(evt_valid), 32'd0);
        check_val("rst_id", 32'(evt_id), 32'd0);
        check_val("rst_ovf", 32'(evt_overflow), 32'd0);
        reset_n = 1'b1;

        // single event, three edges of latency, level held high yields nothing more
        evt_ready = 1'b1;
        level_in  = 4'b0100;
        cycle(); cycle();
        check_val("lat_early", 32'(evt_valid), 32'd0);
        cycle();
        check_val("lat_valid", 32'(evt_valid), 32'd1);
        check_val("lat_id", 32'(evt_id), 32'd2);
        cycle();
        check_val("lat_one_cycle", 32'(evt_valid), 32'd0);
        cnt = 0;
        repeat (6) begin
            cycle();
            if (evt_valid) cnt++;
        end
        check_val("held_no_more", 32'(cnt), 32'd0);

        // round robin from reset
        do_reset();
        evt_ready = 1'b1;
        level_in  = 4'b1111;
        cycle(); cycle();
        for (int k = 0; k < N; k++) begin
            cycle();
            check_val("rr_valid", 32'(evt_valid), 32'd1);
            check_val("rr_id", 32'(evt_id), 32'(k));
        end
        cycle();
        check_val("rr_idle", 32'(evt_valid), 32'd0);

        // backpressure
        do_reset();
        evt_ready = 1'b0;
        level_in  = 4'b1010;
        cycle(); cycle(); cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_val("bp_valid", 32'(evt_valid), 32'd1);
            check_val("bp_id", 32'(evt_id), 32'd1);
        end
        evt_ready = 1'b1;
        cycle();
        check_val("bp_next_valid", 32'(evt_valid), 32'd1);
        check_val("bp_next_id", 32'(evt_id), 32'd3);
        cycle();
        check_val("bp_drained", 32'(evt_valid), 32'd0);

        // overflow and clear
        do_reset();
        evt_ready = 1'b0;
        level_in  = 4'b0001;
        cycle(); cycle(); cycle();
        check_val("ov_presented", 32'(evt_valid), 32'd1);
        level_in = 4'b0000; cycle();
        level_in = 4'b0001; cycle();
        level_in = 4'b0000; cycle();
        check_val("ov_first_pulse", 32'(evt_overflow), 32'd0);
        level_in = 4'b0001; cycle();
        cycle();
        check_val("ov_second_pulse", 32'(evt_overflow), 32'd1);
        clear_overflow = 1'b1; cycle();
        clear_overflow = 1'b0;
        check_val("ov_cleared", 32'(evt_overflow), 32'd0);
        level_in = 4'b0000; cycle();
        level_in = 4'b0001; cycle();
        clear_overflow = 1'b1; cycle();
        clear_overflow = 1'b0;
        check_val("ov_set_beats_clear", 32'(evt_overflow), 32'd1);
        check_val("ov_still_id0", 32'(evt_id), 32'd0);

        // grant of channel 2 coinciding with a new edge on channel 2
        do_reset();
        evt_ready = 1'b0;
        level_in  = 4'b0101;
        cycle(); cycle(); cycle();
        check_val("coll_first_id", 32'(evt_id), 32'd0);
        level_in = 4'b0001; cycle();
        level_in = 4'b0101; cycle();
        evt_ready = 1'b1;
        cnt = 0;
        repeat (6) begin
            cycle();
            if (evt_valid && evt_id == 2'd2) cnt++;
        end
        check_val("coll_two_events", 32'(cnt), 32'd2);
        check_val("coll_no_ovf", 32'(evt_overflow), 32'd0);

        // asynchronous reset mid-operation
        do_reset();
        evt_ready = 1'b0;
        level_in  = 4'b1110;
        cycle(); cycle(); cycle(); cycle();
        check_val("ar_before_id", 32'(evt_id), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("ar_valid", 32'(evt_valid), 32'd0);
        check_val("ar_id", 32'(evt_id), 32'd0);
        check_val("ar_ovf", 32'(evt_overflow), 32'd0);
        model_reset();
        level_in = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        cnt = 0;
        repeat (8) begin
            cycle();
            if (evt_valid && evt_id == 2'd1) cnt++;
        end
        check_val("ar_one_event", 32'(cnt), 32'd1);

        // random traffic against the model
        do_reset();
        repeat (800) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) level_in[i] = ~level_in[i];
            evt_ready      = ($urandom_range(3) != 0);
            clear_overflow = ($urandom_range(15) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_event_arbiter.md
# pulse_event_arbiter

Multi-channel rising-edge event collector and round-robin arbiter. Each of N level inputs is registered twice and edge-detected. Detected rising edges are latched as pending requests. Pending requests are granted one at a time, round-robin, onto a single valid/ready event port carrying the channel ID. This block sits between a bank of level sources (buttons, status flags) and a shared downstream consumer that handles one event per accepted transfer. Lost events are reported per channel.

## Interface
- N, default 4: number of level channels (2..16).
- IDW, default $clog2(N): width of the channel ID.
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears all state immediately; release is synchronous to clk upstream.
- level_in  input  N  level inputs, one per channel; may be asynchronous to clk.
- evt_valid  output  1  an event is presented on evt_id.
- evt_ready  input  1  the consumer accepts the event when evt_valid && evt_ready at a clk edge.
- evt_id  output  IDW  channel number of the presented event.
- evt_overflow  output  N  sticky per-channel flag: an edge was dropped because that channel's previous event was still pending.
- clear_overflow  input  1  clears all evt_overflow bits at the next edge.

## Operation
- Per channel i: reg1[i] <= level_in[i]; reg2[i] <= reg1[i]; edge[i] = reg1[i] & ~reg2[i] (combinational).
- pending[i] (register): set by edge[i]; cleared when channel i is loaded into the output register. If both happen in the same cycle, pending[i] stays 1 (the new edge is a new event).
- Output register (evt_valid, evt_id) loads when (!evt_valid || evt_ready) && |pending. Otherwise it holds.
- The load selects the first set pending bit scanning from (last_grant+1) mod N upward, with wrap-around. last_grant <= the selected ID on each load.
- On reset, last_grant = N-1, so channel 0 has the highest priority first.
- When evt_valid && evt_ready and no pending bit is set, evt_valid <= 0 and evt_id holds its value.
- evt_id and evt_valid are stable while evt_valid && !evt_ready.
- Overflow: evt_overflow[i] <= 1 when edge[i] && pending[i] && channel i is not being loaded this cycle. The edge is discarded.
- clear_overflow clears all overflow bits. A set in the same cycle wins over the clear for that bit.
- An edge on a channel whose event sits in the output register (already granted, not yet accepted) is not an overflow. It sets pending normally.

## Timing
- Reset values: reg1 = reg2 = pending = 0, evt_valid = 0, evt_id = 0, evt_overflow = 0, last_grant = N-1.
- Latency, idle output, no competing channels:
  - level_in high first sampled at edge E0 → reg1 = 1 after E0.
  - pending = 1 after E1.
  - evt_valid = 1 with evt_id = i after E2.
- Back-to-back: with evt_ready held high and multiple channels pending, one event is accepted per cycle with no bubbles.
- A level held high produces exactly one event. The next event requires a low level seen for at least one cycle (reg1 = 0), then high again.
- Reset asserted mid-operation: all state clears immediately. Pending and presented events are dropped with no handshake.
- A level_in already high at reset release produces one event: reg1 = 1 and reg2 = 0 on the first edge after release.
- Max sustained event rate per channel without overflow: one edge per consumer acceptance of that channel.

## Test plan
- Single event: N=4, evt_ready = 1, raise level_in[2] after reset → evt_valid = 1 with evt_id = 2 exactly 3 edges later, for one cycle. Holding the level high gives no further events.
- Round-robin fairness: raise level_in = 4'b1111 in one cycle with evt_ready = 1 → evt_id sequence 0, 1, 2, 3 on consecutive cycles, then evt_valid = 0.
- Backpressure: evt_ready = 0 while channels 1 and 3 are pending → evt_valid and evt_id = 1 held stable for 10 cycles. Raise evt_ready → ids 1 then 3 accepted on consecutive edges.
- Overflow: evt_ready = 0 with channel 0's event presented. Pulse channel 0 twice more (low-high twice) → first pulse sets pending, second sets evt_overflow[0] = 1. Pulse clear_overflow → bit returns to 0, unless a new overflow occurs in the same cycle.
- Grant/edge collision: channel 2 pending and being loaded in the same cycle as a new edge[2] → pending[2] remains 1, no overflow, and two events with id 2 are delivered.
- Async reset: assert reset_n low between clock edges while events are pending and presented → all outputs 0 immediately. With level_in[1] high at release → exactly one event with id 1.
